gpc_col_accum: RTL
==================

Name: gpc_col_accum

Overview:
- Sequential consumer placed directly downstream of a generated GPC (e.g. gpc1_1 or a wider gpcN_M).
- Takes the GPC's weighted-count output word once per accepted beat and accumulates it over a frame delimited by in_last.
- Presents the frame total, beat count and overflow flag on a valid/ready output port.
- Used to reduce a streamed column to a single population count without building a full compressor tree.

Parameters:
- IN_W, 1, width of the GPC dst word consumed per beat; 1 matches gpc1_1.
- ACC_W, 16, width of the accumulated sum; must be >= IN_W.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  IN_W  GPC dst word, unsigned.
- in_last  input  1  marks the final beat of a frame; sampled only on an accepted beat.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  saturated frame sum.
- out_count  output  CNT_W  saturated number of beats in the frame.
- out_ovf  output  1  sum or count saturated during the frame.

Behaviour:
- Reset (rst=1 at a clock edge): state=ACCUM; acc=0; cnt=0; ovf=0; out_valid=0; out_sum=0; out_count=0; out_ovf=0.
  - Reset wins over any concurrent handshake.
  - A frame in progress is discarded and no partial result is emitted.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid & in_ready. Cycles with in_valid=0 are bubbles and leave all state unchanged.
  - On an accepted beat:
    - acc_next = sat(acc + zero_ext(in_data)).
    - cnt_next = sat(cnt + 1).
    - ovf_next = ovf | either saturation event.
  - Accepted beat with in_last=0: stay in ACCUM.
  - Accepted beat with in_last=1:
    - Register out_sum=acc_next, out_count=cnt_next, out_ovf=ovf_next.
    - Clear acc, cnt and ovf to 0 and go to HOLD.
    - out_valid=1 in the next cycle. Latency is 1 cycle, and the last beat is included in the result.
- HOLD:
  - in_ready=0 (back-pressure upstream) and out_valid=1.
  - out_sum, out_count and out_ovf are stable until the handshake.
  - On out_valid & out_ready: go to ACCUM and drop out_valid the next cycle. The output registers keep their last value.
  - No same-cycle turnaround: the next frame's first beat can be accepted one cycle after the output handshake.
- Saturation:
  - sat() clamps to all-ones of the destination width (ACC_W for the sum, CNT_W for the count).
  - Once saturated, further beats hold the all-ones value.
  - ovf is sticky for the frame.
- Single-beat frame (in_last on the first beat): the result equals that beat, with out_count=1.
- The outputs must be registers with no combinational path from in_* to out_*.
- in_ready is a function of state only, so there is no combinational path from out_ready to in_ready.

Decomposition:
- Package gpc_pkg:
  - State enum: ACCUM, HOLD.
  - Default widths (IN_W, ACC_W, CNT_W).
  - A sat_add function, parameterised by width, that returns {ovf, sum}.
- One sub-module is natural: gpc_sat_add.
  - Combinational saturating adder, ACC_W wide, with a carry-out used as the overflow flag.
  - Instantiated twice: for the sum (addend in_data) and for the count (addend 1).
- The FSM and registers stay in gpc_col_accum.

Test Plan:
- Reset then basic frame: IN_W=1, beats 1,0,1,1 with in_last on the 4th, out_ready=1 → out_valid pulses one cycle after beat 4; out_sum=3, out_count=4, out_ovf=0.
- Bubbles plus back-pressure: IN_W=2, beats 3,_,2,_,1(last) with in_valid gaps and out_ready=0 for 5 cycles →
  - out_sum=6, out_count=3.
  - out_valid held 5 cycles with stable data.
  - in_ready=0 throughout HOLD.
  - Accepted on the first cycle with out_ready=1.
- Saturation: ACC_W=4, IN_W=3, beats 7,7,7(last) → out_sum=15, out_count=3, out_ovf=1. The next frame of 1(last) gives out_sum=1, out_ovf=0 (sticky flag cleared per frame).
- Count saturation: CNT_W=2, five beats of 0 with last on the 5th → out_count=3, out_sum=0, out_ovf=1.
- Reset mid-frame: beats 1,1 then rst=1 for one cycle, then beat 1(last) → out_sum=1, out_count=1, with no out_valid before the reset.
- Reset during HOLD: rst while out_valid=1 and out_ready=0 → out_valid=0, in_ready=1 and outputs 0 on the next cycle.

Source files
------------

// File: rtl/gpc_pkg.sv
// Shared types, default widths and a saturating-add helper for the GPC column accumulator.
package gpc_pkg;

   localparam int unsigned DefInW  = 1;
   localparam int unsigned DefAccW = 16;
   localparam int unsigned DefCntW = 8;
   localparam int unsigned SatMaxW = 32;

   typedef enum logic [0:0] {
      StAccum,
      StHold
   } gpc_state_e;

   // Returns {ovf, sum} for a w-bit saturating add; operands must already fit in w bits.
   function automatic logic [SatMaxW:0] sat_add(
      input logic [SatMaxW-1:0] a,
      input logic [SatMaxW-1:0] b,
      input int unsigned        w
   );
      logic [SatMaxW:0] full;
      logic [SatMaxW:0] lim;
      logic             ovf;
      full = {1'b0, a} + {1'b0, b};
      lim  = ((SatMaxW + 1)'(1) << w) - (SatMaxW + 1)'(1);
      ovf  = |(full & ~lim);
      return {ovf, ovf ? lim[SatMaxW-1:0] : full[SatMaxW-1:0]};
   endfunction

endpackage

// File: rtl/gpc_sat_add.sv
// Combinational W-bit saturating adder; the carry-out doubles as the overflow flag.
module gpc_sat_add #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   logic [W:0] full;

   always_comb begin
      full  = {1'b0, a_i} + {1'b0, b_i};
      ovf_o = full[W];
      sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
   end

endmodule

// File: rtl/gpc_col_accum.sv
// Accumulates GPC count words over an in_last-delimited frame and holds the saturated
// total, beat count and overflow flag on a registered valid/ready output.
module gpc_col_accum
   import gpc_pkg::*;
#(
   parameter int unsigned IN_W  = DefInW,
   parameter int unsigned ACC_W = DefAccW,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [IN_W-1:0]  in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ACC_W-1:0] out_sum_o,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_ovf_o
);

   gpc_state_e state_q, state_d;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] in_ext;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt_sum;
   logic             acc_of;
   logic             cnt_of;
   logic             beat;
   logic             frame_ovf;

   assign in_ext = ACC_W'(in_data_i);

   gpc_sat_add #(
      .W (ACC_W)
   ) u_sum_add (
      .a_i   (acc_q),
      .b_i   (in_ext),
      .sum_o (acc_sum),
      .ovf_o (acc_of)
   );

   gpc_sat_add #(
      .W (CNT_W)
   ) u_cnt_add (
      .a_i   (cnt_q),
      .b_i   (CNT_W'(1)),
      .sum_o (cnt_sum),
      .ovf_o (cnt_of)
   );

   assign beat      = in_valid_i & in_ready_o;
   assign frame_ovf = ovf_q | acc_of | cnt_of;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StAccum;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StAccum: if (beat && in_last_i) state_d = StHold;
         StHold:  if (out_ready_i)       state_d = StAccum;
         default: state_d = StAccum;
      endcase
   end

   // Handshake outputs depend on state only, keeping out_ready off the in_ready path.
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      unique case (state_q)
         StAccum: in_ready_o  = 1'b1;
         StHold:  out_valid_o = 1'b1;
         default: in_ready_o  = 1'b0;
      endcase
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      if (beat) begin
         if (in_last_i) begin
            out_sum_d   = acc_sum;
            out_count_d = cnt_sum;
            out_ovf_d   = frame_ovf;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_sum;
            ovf_d = frame_ovf;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_sum_o   = out_sum_q;
   assign out_count_o = out_count_q;
   assign out_ovf_o   = out_ovf_q;

endmodule
